// File: rtl/sh7604_mac_fetch_pkg.sv
// Shared encodings for the SH7604 MAC.W/MAC.L operand-fetch sequencer.
// Holds the state enum, multiplier opcodes, bus size codes and the alignment helper.
package sh7604_mac_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_WR1,
        ST_RD2,
        ST_WR2,
        ST_FIN,
        ST_ERR
    } mac_fetch_state_e;

    localparam logic [3:0] MACOP_MACL = 4'b1001;
    localparam logic [3:0] MACOP_MACW = 4'b1011;

    localparam logic [1:0] MEMSZ_NONE = 2'b00;
    localparam logic [1:0] MEMSZ_WORD = 2'b01;
    localparam logic [1:0] MEMSZ_LONG = 2'b10;

    localparam logic [1:0] MACSEL_A = 2'b01;
    localparam logic [1:0] MACSEL_B = 2'b10;

    // Long operands need 4-byte alignment, word operands need 2-byte alignment.
    function automatic logic misaligned(input logic is_long, input logic [1:0] a_lo);
        return is_long ? (a_lo != 2'b00) : a_lo[0];
    endfunction

endpackage

// File: rtl/sh7604_mac_fetch.sv
// Operand-fetch sequencer for MAC.W/MAC.L @Rm+,@Rn+: two bus reads, two multiplier
// operand writes, then post-incremented Rn/Rm. All state advances only with CE_R.
module sh7604_mac_fetch
    import sh7604_mac_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_L,
    input  logic              CMD_S,
    input  logic              CMD_SAME,
    input  logic [ADDR_W-1:0] CMD_RN,
    input  logic [ADDR_W-1:0] CMD_RM,
    output logic [ADDR_W-1:0] MEM_A,
    output logic              MEM_REQ,
    output logic [1:0]        MEM_SZ,
    input  logic [31:0]       MEM_DI,
    input  logic              MEM_BUSY,
    output logic [1:0]        MAC_SEL,
    output logic [3:0]        MAC_OP,
    output logic              MAC_S,
    output logic              MAC_WE,
    output logic [31:0]       MAC_DO,
    output logic [ADDR_W-1:0] MAC_A,
    output logic [ADDR_W-1:0] RN_NEW,
    output logic [ADDR_W-1:0] RM_NEW,
    output logic              DONE,
    output logic              ADDR_ERR
);

    mac_fetch_state_e  state_q;
    logic              l_q, s_q, same_q;
    logic [ADDR_W-1:0] rn_q, rm_q;
    logic [1:0]        mac_sel_q;
    logic [3:0]        mac_op_q;
    logic              mac_s_q, mac_we_q, done_q, addr_err_q;
    logic [31:0]       mac_do_q;
    logic [ADDR_W-1:0] mac_a_q, rn_new_q, rm_new_q;

    logic [ADDR_W-1:0] inc_d, a2_d;

    // With CMD_SAME both reads walk up from Rn, so the second address is Rn+INC.
    assign inc_d = l_q ? ADDR_W'(4) : ADDR_W'(2);
    assign a2_d  = same_q ? rn_q + inc_d : rm_q;

    assign CMD_READY = (state_q == ST_IDLE);
    assign MEM_REQ   = (state_q == ST_RD1) || (state_q == ST_RD2);
    assign MEM_A     = (state_q == ST_RD1) ? rn_q :
                       (state_q == ST_RD2) ? a2_d : '0;
    assign MEM_SZ    = MEM_REQ ? (l_q ? MEMSZ_LONG : MEMSZ_WORD) : MEMSZ_NONE;

    assign MAC_SEL  = mac_sel_q;
    assign MAC_OP   = mac_op_q;
    assign MAC_S    = mac_s_q;
    assign MAC_WE   = mac_we_q;
    assign MAC_DO   = mac_do_q;
    assign MAC_A    = mac_a_q;
    assign RN_NEW   = rn_new_q;
    assign RM_NEW   = rm_new_q;
    assign DONE     = done_q;
    assign ADDR_ERR = addr_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            l_q        <= 1'b0;
            s_q        <= 1'b0;
            same_q     <= 1'b0;
            rn_q       <= '0;
            rm_q       <= '0;
            mac_sel_q  <= '0;
            mac_op_q   <= '0;
            mac_s_q    <= 1'b0;
            mac_we_q   <= 1'b0;
            mac_do_q   <= '0;
            mac_a_q    <= '0;
            rn_new_q   <= '0;
            rm_new_q   <= '0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (CE_R) begin
            mac_we_q  <= 1'b0;
            mac_sel_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        l_q      <= CMD_L;
                        s_q      <= CMD_S;
                        same_q   <= CMD_SAME;
                        rn_q     <= CMD_RN;
                        rm_q     <= CMD_RM;
                        mac_s_q  <= CMD_S;
                        mac_op_q <= CMD_L ? MACOP_MACL : MACOP_MACW;
                        state_q  <= misaligned(CMD_L, CMD_RN[1:0]) ? ST_ERR : ST_RD1;
                    end
                end
                ST_RD1: begin
                    if (!MEM_BUSY) begin
                        mac_do_q  <= MEM_DI;
                        mac_a_q   <= rn_q;
                        mac_sel_q <= MACSEL_A;
                        mac_we_q  <= 1'b1;
                        state_q   <= ST_WR1;
                    end
                end
                ST_WR1: state_q <= misaligned(l_q, a2_d[1:0]) ? ST_ERR : ST_RD2;
                ST_RD2: begin
                    if (!MEM_BUSY) begin
                        mac_do_q  <= MEM_DI;
                        mac_a_q   <= a2_d;
                        mac_sel_q <= MACSEL_B;
                        mac_we_q  <= 1'b1;
                        state_q   <= ST_WR2;
                    end
                end
                ST_WR2: begin
                    // a2_d+INC covers both cases: Rm+INC, or Rn+2*INC when the registers alias.
                    rn_new_q <= same_q ? a2_d + inc_d : rn_q + inc_d;
                    rm_new_q <= a2_d + inc_d;
                    done_q   <= 1'b1;
                    state_q  <= ST_FIN;
                end
                ST_FIN: state_q <= ST_IDLE;
                ST_ERR: begin
                    // First ERR cycle raises the pulse, second drops it and leaves.
                    if (addr_err_q) begin
                        addr_err_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        addr_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sh7604_mac_fetch.sv
// Scoreboard bench for sh7604_mac_fetch: a bus responder model plus an event queue
// of expected MAC_WE / DONE / ADDR_ERR pulses with cycle offsets from command accept.
module tb_sh7604_mac_fetch;

    logic        CLK = 1'b0, RST = 1'b1, CE_R = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_L = 1'b0, CMD_S = 1'b0, CMD_SAME = 1'b0;
    logic [31:0] CMD_RN = '0, CMD_RM = '0, MEM_DI = '0;
    logic        MEM_BUSY = 1'b0;
    logic        CMD_READY, MEM_REQ, MAC_S, MAC_WE, DONE, ADDR_ERR;
    logic [31:0] MEM_A, MAC_DO, MAC_A, RN_NEW, RM_NEW;
    logic [1:0]  MEM_SZ, MAC_SEL;
    logic [3:0]  MAC_OP;

    sh7604_mac_fetch #(.ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_L(CMD_L), .CMD_S(CMD_S),
        .CMD_SAME(CMD_SAME), .CMD_RN(CMD_RN), .CMD_RM(CMD_RM),
        .MEM_A(MEM_A), .MEM_REQ(MEM_REQ), .MEM_SZ(MEM_SZ), .MEM_DI(MEM_DI), .MEM_BUSY(MEM_BUSY),
        .MAC_SEL(MAC_SEL), .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE), .MAC_DO(MAC_DO),
        .MAC_A(MAC_A), .RN_NEW(RN_NEW), .RM_NEW(RM_NEW), .DONE(DONE), .ADDR_ERR(ADDR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;  // 0 = MAC_WE, 1 = DONE, 2 = ADDR_ERR
        logic [1:0]  sel;
        logic [31:0] data;
        logic [31:0] a;
        logic [3:0]  op;
        logic        s;
        logic [31:0] rn;
        logic [31:0] rm;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        int          busy;
    } rd_t;

    ev_t evq[$];
    rd_t rdq[$];
    int  total = 0, bad = 0, cyc = 0, c0 = 0, acc_cnt = 0, wcnt = 0;
    bit  ce_mode = 1'b0;
    logic [31:0] last_rn = '0, last_rm = '0;

    ev_t m_e;
    int  m_kind;
    bit  m_ok;

    always @(posedge CLK) cyc <= cyc + 1;

    // Clock-enable pattern and memory responder.
    always @(negedge CLK) begin
        CE_R = ce_mode ? ~CE_R : 1'b1;
        MEM_BUSY = 1'b0;
        if (MEM_REQ) begin
            if (rdq.size() == 0) begin
                total++; bad++;
                if (bad < 30) $display("FAIL mem_unexpected_req: MEM_A=%h, no read expected", MEM_A);
            end else begin
                if (CE_R) begin
                    total++;
                    if (MEM_A !== rdq[0].a || MEM_SZ !== rdq[0].sz) begin
                        bad++;
                        $display("FAIL mem_addr: A=%h SZ=%b, required A=%h SZ=%b",
                                 MEM_A, MEM_SZ, rdq[0].a, rdq[0].sz);
                    end
                end
                if (wcnt < rdq[0].busy) begin
                    MEM_BUSY = 1'b1;
                    if (CE_R) wcnt++;
                end else begin
                    MEM_DI = rdq[0].d;
                    if (CE_R) begin
                        void'(rdq.pop_front());
                        wcnt = 0;
                    end
                end
            end
        end
    end

    // Output monitor: pulses count only in enabled cycles.
    always @(negedge CLK) begin
        #1;
        if (!RST && CE_R) begin
            if (CMD_VALID && CMD_READY) begin
                c0 = cyc;
                acc_cnt++;
            end
            if (MAC_WE || DONE || ADDR_ERR) begin
                m_kind = MAC_WE ? 0 : (DONE ? 1 : 2);
                total++;
                if (evq.size() == 0) begin
                    bad++;
                    if (bad < 30) $display("FAIL unexpected_pulse: kind=%0d at rel cycle %0d, none expected",
                                           m_kind, cyc - c0);
                end else begin
                    m_e  = evq.pop_front();
                    m_ok = (m_kind == m_e.kind) && ((cyc - c0) == m_e.cyc);
                    if (m_e.kind == 0)
                        m_ok = m_ok && MAC_SEL === m_e.sel && MAC_DO === m_e.data &&
                               MAC_A === m_e.a && MAC_OP === m_e.op && MAC_S === m_e.s;
                    if (m_e.kind == 1)
                        m_ok = m_ok && RN_NEW === m_e.rn && RM_NEW === m_e.rm;
                    if (!m_ok) begin
                        bad++;
                        $display("FAIL pulse: got kind=%0d rel=%0d sel=%b do=%h a=%h op=%b s=%b rn=%h rm=%h, required kind=%0d rel=%0d sel=%b do=%h a=%h op=%b s=%b rn=%h rm=%h",
                                 m_kind, cyc - c0, MAC_SEL, MAC_DO, MAC_A, MAC_OP, MAC_S, RN_NEW, RM_NEW,
                                 m_e.kind, m_e.cyc, m_e.sel, m_e.data, m_e.a, m_e.op, m_e.s, m_e.rn, m_e.rm);
                    end
                end
            end
        end
    end

    task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input int busy);
        rd_t r;
        r.a = a; r.d = d; r.sz = sz; r.busy = busy;
        rdq.push_back(r);
    endtask

    task automatic push_we(input logic [1:0] sel, input logic [31:0] d, input logic [31:0] a,
                           input logic [3:0] op, input logic s, input int c);
        ev_t e;
        e = '{kind: 0, sel: sel, data: d, a: a, op: op, s: s, rn: '0, rm: '0, cyc: c};
        evq.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] rn, input logic [31:0] rm, input int c);
        ev_t e;
        e = '{kind: 1, sel: '0, data: '0, a: '0, op: '0, s: 1'b0, rn: rn, rm: rm, cyc: c};
        evq.push_back(e);
        last_rn = rn;
        last_rm = rm;
    endtask

    task automatic push_err(input int c);
        ev_t e;
        e = '{kind: 2, sel: '0, data: '0, a: '0, op: '0, s: 1'b0, rn: '0, rm: '0, cyc: c};
        evq.push_back(e);
    endtask

    task automatic issue(input bit l, input bit s, input bit same, input logic [31:0] rn,
                         input logic [31:0] rm, output int acc_cyc);
        int n0;
        n0 = acc_cnt;
        @(negedge CLK);
        CMD_L = l; CMD_S = s; CMD_SAME = same; CMD_RN = rn; CMD_RM = rm;
        CMD_VALID = 1'b1;
        for (int i = 0; i < 200 && acc_cnt == n0; i++) @(posedge CLK);
        if (acc_cnt == n0) begin
            total++; bad++;
            $display("FAIL accept_timeout: command Rn=%h not accepted, required acceptance", rn);
        end
        #1 CMD_VALID = 1'b0;
        acc_cyc = c0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && (evq.size() != 0 || rdq.size() != 0); i++) @(negedge CLK);
        @(negedge CLK);
        total++;
        if (evq.size() != 0 || rdq.size() != 0) begin
            bad++;
            $display("FAIL completion: pending events=%0d reads=%0d, required 0 and 0", evq.size(), rdq.size());
            evq.delete();
            rdq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK); #2;
        total++;
        if ({CMD_READY, MEM_REQ, MAC_WE, DONE, ADDR_ERR, MAC_SEL, MAC_OP, MEM_SZ, MAC_S} !== 14'b1_0000_0000_0000_0) begin
            bad++;
            $display("FAIL reset_ctrl: rdy=%b req=%b we=%b done=%b err=%b sel=%b op=%b sz=%b s=%b, required rdy=1 rest 0",
                     CMD_READY, MEM_REQ, MAC_WE, DONE, ADDR_ERR, MAC_SEL, MAC_OP, MEM_SZ, MAC_S);
        end
        total++;
        if ({RN_NEW, RM_NEW, MAC_DO, MAC_A, MEM_A} !== 160'd0) begin
            bad++;
            $display("FAIL reset_data: rn=%h rm=%h do=%h a=%h mema=%h, required all 0", RN_NEW, RM_NEW, MAC_DO, MAC_A, MEM_A);
        end
    endtask

    task automatic test_macl_basic();
        int a;
        push_rd(32'h1000, 32'h0000_0003, 2'b10, 0);
        push_rd(32'h2000, 32'hFFFF_FFFE, 2'b10, 0);
        push_we(2'b01, 32'h0000_0003, 32'h1000, 4'b1001, 1'b0, 2);
        push_we(2'b10, 32'hFFFF_FFFE, 32'h2000, 4'b1001, 1'b0, 4);
        push_done(32'h1004, 32'h2004, 5);
        issue(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, a);
        wait_done();
    endtask

    task automatic test_macw_wait();
        int a;
        push_rd(32'h1002, 32'hAAAA_5555, 2'b01, 3);
        push_rd(32'h3000, 32'h1234_8765, 2'b01, 3);
        push_we(2'b01, 32'hAAAA_5555, 32'h1002, 4'b1011, 1'b1, 5);
        push_we(2'b10, 32'h1234_8765, 32'h3000, 4'b1011, 1'b1, 10);
        push_done(32'h1004, 32'h3002, 11);
        issue(1'b0, 1'b1, 1'b0, 32'h1002, 32'h3000, a);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int a0, a1;
        push_rd(32'h4000, 32'h0101_0101, 2'b10, 0);
        push_rd(32'h4004, 32'h0202_0202, 2'b10, 0);
        push_we(2'b01, 32'h0101_0101, 32'h4000, 4'b1001, 1'b0, 2);
        push_we(2'b10, 32'h0202_0202, 32'h4004, 4'b1001, 1'b0, 4);
        push_done(32'h4008, 32'h4008, 5);
        issue(1'b1, 1'b0, 1'b1, 32'h4000, 32'h4000, a0);
        push_rd(32'hFFFF_FFFC, 32'h8000_0001, 2'b10, 0);
        push_rd(32'h0000_0100, 32'h7FFF_FFFF, 2'b10, 0);
        push_we(2'b01, 32'h8000_0001, 32'hFFFF_FFFC, 4'b1001, 1'b0, 2);
        push_we(2'b10, 32'h7FFF_FFFF, 32'h0000_0100, 4'b1001, 1'b0, 4);
        push_done(32'h0000_0000, 32'h0000_0104, 5);
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0100, a1);
        total++;
        if (a1 - a0 !== 6) begin
            bad++;
            $display("FAIL b2b_accept: next accept after %0d cycles, required 6", a1 - a0);
        end
        wait_done();
    endtask

    task automatic test_addr_err();
        int a0, a1;
        push_err(2);
        issue(1'b1, 1'b0, 1'b0, 32'h1002, 32'h2000, a0);
        push_rd(32'h1000, 32'h0000_0077, 2'b10, 0);
        push_we(2'b01, 32'h0000_0077, 32'h1000, 4'b1001, 1'b0, 2);
        push_err(4);
        issue(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2001, a1);
        total++;
        if (a1 - a0 !== 3) begin
            bad++;
            $display("FAIL err_accept: next accept after %0d cycles, required 3", a1 - a0);
        end
        wait_done();
        total++;
        if (RN_NEW !== last_rn || RM_NEW !== last_rm || DONE !== 1'b0) begin
            bad++;
            $display("FAIL err_regs: rn=%h rm=%h done=%b, required rn=%h rm=%h done=0",
                     RN_NEW, RM_NEW, DONE, last_rn, last_rm);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        push_rd(32'h5000, 32'h0000_0011, 2'b10, 0);
        push_rd(32'h6000, 32'h0000_0022, 2'b10, 100);
        push_we(2'b01, 32'h0000_0011, 32'h5000, 4'b1001, 1'b0, 2);
        issue(1'b1, 1'b0, 1'b0, 32'h5000, 32'h6000, a);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #2;
        total++;
        if ({CMD_READY, MEM_REQ, MAC_WE, DONE, ADDR_ERR} !== 5'b10000 || RN_NEW !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: rdy=%b req=%b we=%b done=%b err=%b rn=%h, required rdy=1 req=0 we=0 done=0 err=0 rn=0",
                     CMD_READY, MEM_REQ, MAC_WE, DONE, ADDR_ERR, RN_NEW);
        end
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_we: %0d expected pulses not seen, required 0", evq.size());
            evq.delete();
        end
        rdq.delete();
        wcnt = 0;
        last_rn = '0;
        last_rm = '0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_ce_toggle();
        int a;
        ce_mode = 1'b1;
        push_rd(32'h1000, 32'h0000_0003, 2'b10, 0);
        push_rd(32'h2000, 32'hFFFF_FFFE, 2'b10, 0);
        push_we(2'b01, 32'h0000_0003, 32'h1000, 4'b1001, 1'b0, 4);
        push_we(2'b10, 32'hFFFF_FFFE, 32'h2000, 4'b1001, 1'b0, 8);
        push_done(32'h1004, 32'h2004, 10);
        issue(1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, a);
        wait_done();
        ce_mode = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_macl_basic();
        test_macw_wait();
        test_back_to_back();
        test_addr_err();
        test_reset_mid();
        test_ce_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
